// File: rtl/maze_if.sv
// Pixel/Pac-Man query bus between the game side and the playfield.
interface maze_if;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [9:0] pac_x;
    logic [9:0] pac_y;
    logic       eat_en;
    logic [1:0] tile_info;
    logic [7:0] color;

    modport master (
        output xpos, ypos, pac_x, pac_y, eat_en,
        input  tile_info, color
    );

    modport slave (
        input  xpos, ypos, pac_x, pac_y, eat_en,
        output tile_info, color
    );
endinterface

// File: rtl/maze.sv
// Pac-Man playfield: fixed wall/dot/pellet layout, per-tile "present" bits,
// registered pixel colour and registered tile type under Pac-Man.
module maze #(
    parameter int unsigned TILE_BITS = 3,
    parameter int unsigned COLS      = 20,
    parameter int unsigned ROWS      = 40,
    parameter logic [7:0]  C_WALL    = 8'h03,
    parameter logic [7:0]  C_DOT     = 8'hFF,
    parameter logic [7:0]  C_PELLET  = 8'hFC,
    parameter logic [7:0]  C_BG      = 8'h00
) (
    input logic   clk,
    input logic   rst,
    maze_if.slave bus
);

    localparam int unsigned NumTiles = COLS * ROWS;
    localparam logic [9:0]  NumCols  = 10'(COLS);
    localparam logic [9:0]  NumRows  = 10'(ROWS);
    localparam logic [9:0]  LastCol  = 10'(COLS - 1);
    localparam logic [9:0]  LastRow  = 10'(ROWS - 1);
    localparam logic [9:0]  NearCol  = 10'(COLS - 2);
    localparam logic [9:0]  NearRow  = 10'(ROWS - 2);

    typedef enum logic [1:0] {
        TileEmpty  = 2'b00,
        TileWall   = 2'b01,
        TileDot    = 2'b10,
        TilePellet = 2'b11
    } tile_e;

    // Static layout; walls win over pellets, so a pellet corner that lands on a
    // pillar stays a wall.
    function automatic tile_e layout(input logic [9:0] col, input logic [9:0] row);
        if (col == 10'd0 || col == LastCol || row == 10'd0 || row == LastRow ||
            (col[1:0] == 2'd2 && row[1:0] == 2'd2)) begin
            return TileWall;
        end
        if ((col == 10'd1 || col == NearCol) && (row == 10'd1 || row == NearRow)) begin
            return TilePellet;
        end
        return TileDot;
    endfunction

    logic [NumTiles-1:0] present;
    logic [1:0]          tile_info_q;
    logic [7:0]          color_q;

    logic [9:0] pix_col, pix_row, pac_col, pac_row;
    logic [9:0] pix_idx, pac_idx;
    logic [2:0] ox, oy;
    logic       pix_in, pac_in;
    logic       pix_present, pac_present;
    tile_e      pix_base, pac_base, pix_tile, pac_tile;
    logic       eat_hit;
    logic [1:0] tile_info_d;
    logic [7:0] color_d;

    // Tile lookup for both the scanned pixel and Pac-Man, then colour selection.
    always_comb begin
        pix_col = bus.xpos >> TILE_BITS;
        pix_row = bus.ypos >> TILE_BITS;
        pac_col = bus.pac_x >> TILE_BITS;
        pac_row = bus.pac_y >> TILE_BITS;
        // Dot/pellet artwork is drawn for 8x8 tiles.
        ox      = bus.xpos[2:0];
        oy      = bus.ypos[2:0];
        pix_in  = (pix_col < NumCols) && (pix_row < NumRows);
        pac_in  = (pac_col < NumCols) && (pac_row < NumRows);
        pix_idx = pix_row * NumCols + pix_col;
        pac_idx = pac_row * NumCols + pac_col;

        pix_present = pix_in ? present[pix_idx] : 1'b0;
        pac_present = pac_in ? present[pac_idx] : 1'b0;
        pix_base    = layout(pix_col, pix_row);
        pac_base    = layout(pac_col, pac_row);

        pix_tile = TileEmpty;
        if (pix_in) begin
            if (pix_base == TileWall) pix_tile = TileWall;
            else if (pix_present)     pix_tile = pix_base;
        end

        pac_tile = TileWall;
        if (pac_in) begin
            if (pac_base == TileWall) pac_tile = TileWall;
            else if (pac_present)     pac_tile = pac_base;
            else                      pac_tile = TileEmpty;
        end
        tile_info_d = pac_tile;

        color_d = C_BG;
        case (pix_tile)
            TileWall:   color_d = C_WALL;
            TileDot: begin
                if ((ox == 3'd3 || ox == 3'd4) && (oy == 3'd3 || oy == 3'd4)) color_d = C_DOT;
            end
            TilePellet: begin
                if (ox >= 3'd2 && ox <= 3'd5 && oy >= 3'd2 && oy <= 3'd5) color_d = C_PELLET;
            end
            default:    color_d = C_BG;
        endcase

        // Re-clearing an already eaten tile is harmless, so held eat_en needs no guard.
        eat_hit = bus.eat_en && pac_in && (pac_base != TileWall);
    end

    // Output registers and present bits; reads above see the pre-eat value.
    always_ff @(posedge clk) begin
        if (rst) begin
            present     <= '1;
            tile_info_q <= 2'b00;
            color_q     <= 8'h00;
        end else begin
            tile_info_q <= tile_info_d;
            color_q     <= color_d;
            if (eat_hit) present[pac_idx] <= 1'b0;
        end
    end

    assign bus.tile_info = tile_info_q;
    assign bus.color     = color_q;

endmodule

// File: tb/tb_maze.sv
// Scoreboard bench for maze: stimulus pushes expected outputs, a monitor
// pops and compares them on the falling edge.
module tb_maze;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maze_if bus ();

    maze dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] tile;
        logic [7:0] color;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   eaten[40][20];

    function automatic bit is_wall(input int c, input int r);
        return c == 0 || c == 19 || r == 0 || r == 39 || (c % 4 == 2 && r % 4 == 2);
    endfunction

    function automatic bit is_pellet(input int c, input int r);
        return !is_wall(c, r) && (c == 1 || c == 18) && (r == 1 || r == 38);
    endfunction

    // Tile type as the game sees it (out-of-field counts as wall).
    function automatic logic [1:0] m_info(input int c, input int r);
        if (c >= 20 || r >= 40) return 2'b01;
        if (is_wall(c, r))      return 2'b01;
        if (eaten[r][c])        return 2'b00;
        return is_pellet(c, r) ? 2'b11 : 2'b10;
    endfunction

    function automatic logic [7:0] m_color(input int x, input int y);
        int c, r, ox, oy;
        c  = x / 8;
        r  = y / 8;
        ox = x % 8;
        oy = y % 8;
        if (c >= 20 || r >= 40) return 8'h00;
        case (m_info(c, r))
            2'b01: return 8'h03;
            2'b10: return (ox >= 3 && ox <= 4 && oy >= 3 && oy <= 4) ? 8'hFF : 8'h00;
            2'b11: return (ox >= 2 && ox <= 5 && oy >= 2 && oy <= 5) ? 8'hFC : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // One clock of stimulus; fixed=1 uses the given expectation instead of the model.
    task automatic cycle(input string name, input bit r, input int x, input int y,
                         input int px, input int py, input bit e, input bit fixed,
                         input logic [1:0] ft, input logic [7:0] fc);
        exp_t ex;
        rst        = r;
        bus.xpos   = 10'(x);
        bus.ypos   = 10'(y);
        bus.pac_x  = 10'(px);
        bus.pac_y  = 10'(py);
        bus.eat_en = e;
        ex.name = name;
        if (fixed) begin
            ex.tile  = ft;
            ex.color = fc;
        end else if (r) begin
            ex.tile  = 2'b00;
            ex.color = 8'h00;
        end else begin
            ex.tile  = m_info(px / 8, py / 8);
            ex.color = m_color(x, y);
        end
        @(posedge clk);
        exp_q.push_back(ex);
        if (r) begin
            foreach (eaten[i, j]) eaten[i][j] = 1'b0;
        end else if (e && px / 8 < 20 && py / 8 < 40 && !is_wall(px / 8, py / 8)) begin
            eaten[py / 8][px / 8] = 1'b1;
        end
        #1;
    endtask

    // Monitor: compare registered outputs against the oldest expectation.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                checks++;
                if (bus.tile_info !== ex.tile) begin
                    failures++;
                    $display("FAIL %s tile_info got %b want %b", ex.name, bus.tile_info, ex.tile);
                end
                checks++;
                if (bus.color !== ex.color) begin
                    failures++;
                    $display("FAIL %s color got %h want %h", ex.name, bus.color, ex.color);
                end
            end
        end
    end

    initial begin
        cycle("reset", 1, 0, 0, 0, 0, 1, 1, 2'b00, 8'h00);

        cycle("wall00",    0, 0,   0,   8,   40,  0, 1, 2'b10, 8'h03);
        cycle("dot_pix",   0, 11,  43,  8,   8,   0, 1, 2'b11, 8'hFF);
        cycle("dot_edge",  0, 8,   40,  0,   0,   0, 1, 2'b01, 8'h00);
        cycle("pillar",    0, 20,  20,  200, 0,   0, 1, 2'b01, 8'h03);
        cycle("x_out",     0, 160, 0,   0,   400, 0, 1, 2'b01, 8'h00);
        cycle("y_out",     0, 0,   320, 159, 319, 0, 1, 2'b01, 8'h00);
        cycle("pel_pix",   0, 10,  10,  8,   8,   0, 1, 2'b11, 8'hFC);
        cycle("pel_edge",  0, 8,   8,   144, 304, 0, 1, 2'b01, 8'h00);
        cycle("eat_rbw",   0, 11,  43,  8,   40,  1, 1, 2'b10, 8'hFF);
        cycle("eat_held",  0, 11,  43,  8,   40,  1, 1, 2'b00, 8'h00);
        cycle("eaten",     0, 11,  43,  8,   40,  0, 1, 2'b00, 8'h00);
        cycle("eat_wall",  0, 3,   3,   0,   0,   1, 1, 2'b01, 8'h03);
        cycle("wall_kept", 0, 3,   3,   0,   0,   0, 1, 2'b01, 8'h03);
        cycle("rst_eat",   1, 10,  10,  8,   8,   1, 1, 2'b00, 8'h00);
        cycle("pel_kept",  0, 10,  10,  8,   8,   0, 1, 2'b11, 8'hFC);
        cycle("restored",  0, 11,  43,  8,   40,  0, 1, 2'b10, 8'hFF);

        for (int y = 0; y < 320; y++) begin
            for (int x = 0; x < 160; x++) begin
                cycle("scan", 0, x, y, $urandom_range(0, 175), $urandom_range(0, 335), 0, 0,
                      2'b00, 8'h00);
            end
        end

        for (int n = 0; n < 6000; n++) begin
            cycle("random", ($urandom_range(0, 999) == 0), $urandom_range(0, 179),
                  $urandom_range(0, 339), $urandom_range(0, 175), $urandom_range(0, 335),
                  ($urandom_range(0, 7) == 0), 0, 2'b00, 8'h00);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
